pc_fetch_ctrl: RTL
==================

Name: pc_fetch_ctrl

Overview:
- Sequences the program counter and instruction-memory fetch for the single-cycle core.
- Sits between the branch-condition/PC-select path (branch_taken, branch_target) and the instruction memory.
- Issues one outstanding fetch at a time over a req/ack handshake, and absorbs back-pressure from decode with a one-entry skid buffer.
- Redirects on taken branches and discards any in-flight or buffered instructions from the wrong path.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
PC_STEP, 4, byte increment applied after each accepted instruction.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
run_en  input  1  fetch enable; 0 parks the controller in IDLE once no request is outstanding.
branch_taken  input  1  single-cycle redirect pulse from branch-condition logic.
branch_target  input  32  redirect PC, valid when branch_taken=1.
imem_req  output  1  fetch request to instruction memory.
imem_addr  output  32  fetch address; stable while imem_req=1 and imem_ack=0.
imem_ack  input  1  memory accepted the request; imem_rdata is valid this cycle.
imem_rdata  input  32  instruction word.
instr_valid  output  1  instr_out/instr_pc hold a valid instruction.
instr_out  output  32  instruction to decode.
instr_pc  output  32  PC of instr_out.
stall  input  1  decode not ready; an instruction is consumed when instr_valid=1 and stall=0.
misalign  output  1  sticky misaligned-target flag (only with the optional feature).

Behaviour:
- Reset (asynchronous, any state, including mid-request): pc=RESET_PC, state=IDLE, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr_out=0, instr_pc=0, skid empty, misalign=0. Outstanding memory transactions are abandoned.
- States: IDLE, REQ, DISCARD, TRAP (TRAP exists only with the optional feature).
- IDLE:
  - imem_req=0.
  - Goes to REQ when run_en=1 and a slot is free. Free means the skid is empty and either the output register is empty or it is consumed this cycle.
- REQ:
  - imem_req=1, imem_addr=pc.
  - On imem_ack with no branch:
    - Data goes to the output register if it is free, else to the skid; tag = pc.
    - pc <= pc+PC_STEP.
    - Stay in REQ if run_en=1 and a slot will be free next cycle; otherwise go to IDLE.
  - imem_addr must not change before ack.
- Output register and skid:
  - The output register loads from the skid when consumed and the skid is full.
  - instr_valid is registered: it rises the cycle after the ack, or later if the data was placed in the skid.
- Branch handling (branch_taken=1):
  - Clear instr_valid and the skid on the next edge (flush), whatever the stall value.
  - Ack in the same cycle: the returned data is dropped; pc <= branch_target; REQ next.
  - REQ without ack: latch branch_target into redirect_pc and go to DISCARD.
  - IDLE: pc <= branch_target.
- DISCARD:
  - imem_req=1 with the old address until imem_ack; the returned data is dropped.
  - Then pc <= redirect_pc and go to REQ (or IDLE if run_en=0).
  - A further branch_taken in DISCARD overwrites redirect_pc; the last one wins.
- Simultaneous stall=1 and branch_taken=1: the flush wins.
- PC arithmetic: 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0 with no flag.
- run_en falling mid-request: the request completes, the data is kept, then IDLE.

Optional Feature:
- Macro: PC_MISALIGN_TRAP_EN.
- Defined:
  - A branch_taken with branch_target[1:0]!=0 sets misalign=1 (sticky until rst) and flushes as normal.
  - An outstanding request completes and its data is dropped; then the controller enters TRAP.
  - TRAP: imem_req=0, instr_valid=0; only rst exits.
- Not defined:
  - misalign is tied to 0 and there is no TRAP state.
  - The target is used as-is, with imem_addr[1:0] forced to 2'b00.

Test Plan:
- Reset then run_en=1, imem_ack tied 1, stall=0, rdata=pc^32'hA5A5_0000 -> imem_addr sequence 0,4,8,C. instr_valid from cycle 2 with instr_pc 0,4,8 back-to-back. One instruction per cycle.
- ack 3 cycles late while stall=1 for 4 cycles -> at most 2 instructions buffered. No imem_req while the skid is full. On stall release, instr_pc 0 then 4 in order, none lost or duplicated.
- branch_taken with target 32'h100 while REQ addr 8 awaits ack (ack 2 cycles later) -> imem_addr holds 8 until ack. That data is dropped; next imem_addr=32'h100. instr_valid=0 until the 32'h100 data returns.
- branch_taken in the same cycle as the ack for addr C, target 32'h40 -> the C data never appears. The next request is at 32'h40.
- rst asserted mid-DISCARD -> all outputs immediately return to reset values. The next request is at RESET_PC after run_en.
- With PC_MISALIGN_TRAP_EN: branch to 32'h102 -> misalign=1, imem_req=0 forever, instr_valid=0. Without it: the next imem_addr is 32'h100 and misalign=0.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// Program-counter sequencer: one outstanding imem fetch, one-entry skid buffer, branch flush.
// Optional feature macro PC_MISALIGN_TRAP_EN adds a sticky misalign flag and a TRAP state.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run_en,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  input  logic        stall,
  output logic        misalign
);

  // state   | meaning
  // IDLE    | no fetch outstanding
  // REQ     | fetch of pc outstanding
  // DISCARD | wrong-path fetch outstanding; its data is dropped, then pc <= redirect_pc
  // TRAP    | misaligned branch seen; halted until rst
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_DISCARD = 2'd2
`ifdef PC_MISALIGN_TRAP_EN
    , S_TRAP  = 2'd3
`endif
  } state_t;

`ifdef PC_MISALIGN_TRAP_EN
  localparam state_t S_HALT = S_TRAP;
`else
  localparam state_t S_HALT = S_IDLE;
`endif

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] redirect_q, redirect_d;
  logic        req_q, req_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q, out_data_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_data_q, skid_data_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic        trap_go;
`ifdef PC_MISALIGN_TRAP_EN
  logic        misalign_q, misalign_d;
`endif

  logic        consumed, out_free, slot_free, ack_keep;
  logic [31:0] tgt;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    redirect_d   = redirect_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_pc_d     = out_pc_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_pc_d    = skid_pc_q;

    consumed  = out_valid_q && !stall;
    out_free  = !out_valid_q || consumed;
    slot_free = !skid_valid_q && out_free;
    ack_keep  = (state_q == S_REQ) && imem_ack && !branch_taken;
    tgt       = branch_target & 32'hFFFF_FFFC;

`ifdef PC_MISALIGN_TRAP_EN
    misalign_d = misalign_q | (branch_taken & (branch_target[1:0] != 2'b00));
    trap_go    = misalign_d;
`else
    trap_go    = 1'b0;
`endif

    if (out_free) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        out_pc_d     = skid_pc_q;
        skid_valid_d = ack_keep;
        if (ack_keep) begin
          skid_data_d = imem_rdata;
          skid_pc_d   = pc_q;
        end
      end else if (ack_keep) begin
        out_valid_d = 1'b1;
        out_data_d  = imem_rdata;
        out_pc_d    = pc_q;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (ack_keep) begin
      skid_valid_d = 1'b1;
      skid_data_d  = imem_rdata;
      skid_pc_d    = pc_q;
    end

    // a taken branch always empties both entries, even under stall
    if (branch_taken) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (branch_taken) begin
          pc_d    = tgt;
          state_d = run_en ? S_REQ : S_IDLE;
        end else if (run_en && slot_free) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (imem_ack && branch_taken) begin
          pc_d    = tgt;
          state_d = run_en ? S_REQ : S_IDLE;
        end else if (imem_ack) begin
          pc_d    = pc_q + PC_STEP;
          state_d = (run_en && !skid_valid_d) ? S_REQ : S_IDLE;
        end else if (branch_taken) begin
          redirect_d = tgt;
          state_d    = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (imem_ack) begin
          pc_d    = branch_taken ? tgt : redirect_q;
          state_d = run_en ? S_REQ : S_IDLE;
        end else if (branch_taken) begin
          redirect_d = tgt;
        end
      end
      default: state_d = S_HALT;
    endcase

    // an outstanding fetch must drain before halting
    if (trap_go && state_d != S_DISCARD) state_d = S_HALT;

    req_d = (state_d == S_REQ) || (state_d == S_DISCARD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      redirect_q   <= RESET_PC;
      req_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= 32'd0;
      out_pc_q     <= 32'd0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= 32'd0;
      skid_pc_q    <= 32'd0;
`ifdef PC_MISALIGN_TRAP_EN
      misalign_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      redirect_q   <= redirect_d;
      req_q        <= req_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_pc_q     <= out_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_pc_q    <= skid_pc_d;
`ifdef PC_MISALIGN_TRAP_EN
      misalign_q   <= misalign_d;
`endif
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr_valid = out_valid_q;
  assign instr_out   = out_data_q;
  assign instr_pc    = out_pc_q;
`ifdef PC_MISALIGN_TRAP_EN
  assign misalign    = misalign_q;
`else
  assign misalign    = 1'b0;
`endif

endmodule
